// File: rtl/exhaustive_check_sequencer_if.sv
// exhaustive_check_sequencer_if: control, stimulus and result bundle between the bench and the sweep sequencer
interface exhaustive_check_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] dut_out;
  logic [WIDTH-1:0] ref_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERRW-1:0]  err_count;
  logic [WIDTH-1:0] first_fail_vec;
  logic             first_fail_valid;
  modport master (
    output start, abort, dut_out, ref_out,
    input  stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
  modport slave (
    input  start, abort, dut_out, ref_out,
    output stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/exhaustive_check_sequencer.sv
// exhaustive_check_sequencer: sweeps every WIDTH-bit vector, waits SETTLE cycles, compares dut_out against ref_out
module exhaustive_check_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 8,
  parameter int ERRW   = 8
) (
  input logic clk,
  input logic reset,
  exhaustive_check_sequencer_if.slave bus
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {IDLE, APPLY, SETTLING, COMPARE, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] stim_q, stim_d, ffv_q, ffv_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             ffval_q, ffval_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             mis;
  assign mis = bus.dut_out != bus.ref_out;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (busy_q && bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_d = APPLY;
          stim_d  = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
        APPLY: begin
          cnt_d   = CW'(SETTLE - 1);
          state_d = SETTLING;
        end
        SETTLING: begin
          state_d = (cnt_q == '0) ? COMPARE : SETTLING;
          cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end
        COMPARE: begin
          // the terminal vector's own mismatch must be reflected in pass
          err_d   = (mis && err_q != '1) ? err_q + 1'b1 : err_q;
          ffv_d   = (mis && !ffval_q) ? stim_q : ffv_q;
          ffval_d = ffval_q | mis;
          if (stim_q == '1) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = err_d == '0;
          end else begin
            state_d = APPLY;
            stim_d  = stim_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign bus.stim             = stim_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffval_q;
endmodule

// File: tb/tb_exhaustive_check_sequencer.sv
// tb_exhaustive_check_sequencer: directed sweeps with hand-computed expectations, plus a 3-bit counter saturation instance
module tb_exhaustive_check_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   mode = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n;
  always #5 clk = ~clk;
  exhaustive_check_sequencer_if #(.WIDTH(4), .ERRW(8)) b ();
  exhaustive_check_sequencer_if #(.WIDTH(4), .ERRW(3)) s ();
  exhaustive_check_sequencer #(.WIDTH(4), .SETTLE(8), .ERRW(8)) dut (.clk(clk), .reset(reset), .bus(b));
  exhaustive_check_sequencer #(.WIDTH(4), .SETTLE(8), .ERRW(3)) sat (.clk(clk), .reset(reset), .bus(s));
  assign b.ref_out = ~b.stim;
  always_comb begin
    b.dut_out = ~b.stim;
    if (mode == 1) b.dut_out = ~b.stim & 4'b1011;
    if (mode == 2) b.dut_out = (b.stim == 4'hF) ? 4'h1 : ~b.stim;
  end
  assign s.ref_out = ~s.stim;
  assign s.dut_out = s.stim;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // pulses start, then counts edges until busy drops (or the budget runs out)
  task automatic sweep(input int start_at, input int abort_at, output int cyc);
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    cyc = 0;
    while (cyc < 400 && b.busy) begin
      b.start = (cyc == start_at);
      b.abort = (cyc == abort_at);
      tick();
      cyc++;
    end
    b.start = 1'b0;
    b.abort = 1'b0;
  endtask
  initial begin
    b.start = 1'b0;
    b.abort = 1'b0;
    s.start = 1'b0;
    s.abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_stim", b.stim, 0);
    check("rst_busy", b.busy, 0);
    check("rst_done", b.done, 0);
    check("rst_pass", b.pass, 0);
    check("rst_err", b.err_count, 0);
    check("rst_ffv", b.first_fail_vec, 0);
    check("rst_ffval", b.first_fail_valid, 0);
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
    check("sat_busy", s.busy, 1);
    mode = 0;
    sweep(-1, -1, n);
    check("pass_len", n, 160);
    check("pass_done", b.done, 1);
    check("pass_pass", b.pass, 1);
    check("pass_err", b.err_count, 0);
    check("pass_ffval", b.first_fail_valid, 0);
    check("pass_stim", b.stim, 4'hF);
    check("sat_done", s.done, 1);
    check("sat_err", s.err_count, 7);
    check("sat_pass", s.pass, 0);
    check("sat_ffv", s.first_fail_vec, 0);
    mode = 1;
    sweep(-1, -1, n);
    check("fault_len", n, 160);
    check("fault_err", b.err_count, 8);
    check("fault_ffv", b.first_fail_vec, 0);
    check("fault_ffval", b.first_fail_valid, 1);
    check("fault_pass", b.pass, 0);
    mode = 2;
    sweep(-1, -1, n);
    check("late_len", n, 160);
    check("late_done", b.done, 1);
    check("late_err", b.err_count, 1);
    check("late_ffv", b.first_fail_vec, 4'hF);
    check("late_pass", b.pass, 0);
    mode = 1;
    sweep(-1, 49, n);
    check("abort_len", n, 50);
    check("abort_busy", b.busy, 0);
    check("abort_done", b.done, 0);
    check("abort_err", b.err_count, 4);
    check("abort_ffval", b.first_fail_valid, 1);
    check("abort_stim", b.stim, 4);
    repeat (20) tick();
    check("abort_frozen", b.err_count, 4);
    check("abort_idle", b.busy, 0);
    mode = 0;
    sweep(-1, -1, n);
    check("reabort_len", n, 160);
    check("reabort_err", b.err_count, 0);
    check("reabort_pass", b.pass, 1);
    mode = 1;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    repeat (69) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_stim", b.stim, 0);
    check("mrst_busy", b.busy, 0);
    check("mrst_done", b.done, 0);
    check("mrst_err", b.err_count, 0);
    check("mrst_ffval", b.first_fail_valid, 0);
    check("mrst_ffv", b.first_fail_vec, 0);
    check("mrst_pass", b.pass, 0);
    mode = 0;
    sweep(29, -1, n);
    check("sbusy_len", n, 160);
    check("sbusy_pass", b.pass, 1);
    sweep(30, 30, n);
    check("both_busy_len", n, 31);
    check("both_busy_done", b.done, 0);
    b.start = 1'b1;
    b.abort = 1'b1;
    tick();
    b.start = 1'b0;
    b.abort = 1'b0;
    check("both_idle_busy", b.busy, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
